// File: rtl/main_control_fsm.sv
// Multicycle RV32I main control FSM: Moore decode of state plus instruction fields.
// Optional memory handshake: define MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on mem_ready.
module main_control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic [3:0]  flags,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        illegal
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR   = 4'd2,  S_MEMREAD = 4'd3,
        S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,  S_EXECR    = 4'd6,  S_EXECI   = 4'd7,
        S_ALUWB    = 4'd8,  S_BRANCH   = 4'd9,  S_JAL      = 4'd10, S_JALR_ADR = 4'd11,
        S_JALR_JMP = 4'd12, S_UPPER    = 4'd13, S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011, OP_R    = 7'b0110011,
                           OP_I     = 7'b0010011, OP_BR    = 7'b1100011, OP_JAL  = 7'b1101111,
                           OP_JALR  = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001;

    state_t      r_state, w_next;
    logic        r_illegal;
    logic        w_mem_ok, w_unused;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic        w_f7b5;
    logic        w_pcwrite, w_adrsrc, w_memwrite, w_irwrite, w_regwrite;
    logic [1:0]  w_srca, w_srcb, w_res;
    logic [2:0]  w_imm;
    logic [3:0]  w_alu;

    assign w_op   = Instr[6:0];
    assign w_f3   = Instr[14:12];
    assign w_f7b5 = Instr[30];

`ifdef MEM_WAIT_EN
    assign w_mem_ok = mem_ready;
`else
    assign w_mem_ok = 1'b1;
`endif
    assign w_unused = &{1'b0, mem_ready, Instr[31], Instr[29:15], Instr[11:7]};

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_r);
        logic [3:0] alu;
        case (f3)
            3'b000:  alu = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu = 4'b0111;
            3'b010:  alu = 4'b0101;
            3'b011:  alu = 4'b0110;
            3'b100:  alu = 4'b0100;
            3'b101:  alu = f7b5 ? 4'b1001 : 4'b1000;
            3'b110:  alu = 4'b0011;
            3'b111:  alu = 4'b0010;
            default: alu = ALU_ADD;
        endcase
        return alu;
    endfunction

    // flags: [0] Z, [1] N, [2] C (set = no borrow), [3] V
    function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] f);
        logic t;
        case (f3)
            3'b000:  t = f[0];
            3'b001:  t = ~f[0];
            3'b100:  t = f[1] ^ f[3];
            3'b101:  t = ~(f[1] ^ f[3]);
            3'b110:  t = ~f[2];
            3'b111:  t = f[2];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // State register and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == S_TRAP);
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        w_next     = r_state;
        w_pcwrite  = 1'b0;
        w_adrsrc   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_srca     = 2'b00;
        w_srcb     = 2'b00;
        w_res      = 2'b00;
        w_imm      = 3'b000;
        w_alu      = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_irwrite = w_mem_ok;
                w_pcwrite = w_mem_ok;
                w_srcb    = 2'b10;
                w_res     = 2'b10;
                w_next    = w_mem_ok ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_srca = 2'b01;
                w_srcb = 2'b01;
                w_imm  = (w_op == OP_JAL) ? 3'b011 : 3'b010;
                case (w_op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_BR:             w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR_ADR;
                    OP_LUI, OP_AUIPC:  w_next = S_UPPER;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_srca = 2'b10;
                w_srcb = 2'b01;
                w_imm  = (w_op == OP_STORE) ? 3'b001 : 3'b000;
                w_next = (w_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                w_next   = w_mem_ok ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_res      = 2'b01;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
                w_next     = w_mem_ok ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                w_srca = 2'b10;
                w_alu  = alu_decode(w_f3, w_f7b5, 1'b1);
                w_next = S_ALUWB;
            end
            S_EXECI: begin
                w_srca = 2'b10;
                w_srcb = 2'b01;
                w_alu  = alu_decode(w_f3, w_f7b5, 1'b0);
                w_next = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                w_srca    = 2'b10;
                w_alu     = ALU_SUB;
                w_pcwrite = branch_taken(w_f3, flags);
                w_next    = (w_f3 == 3'b010 || w_f3 == 3'b011) ? S_TRAP : S_FETCH;
            end
            // JALR reuses the JAL jump so the link write lands after rs1 was consumed
            S_JAL, S_JALR_JMP: begin
                w_srca    = 2'b01;
                w_srcb    = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_JALR_ADR: begin
                w_srca = 2'b10;
                w_srcb = 2'b01;
                w_next = S_JALR_JMP;
            end
            S_UPPER: begin
                w_srca = (w_op == OP_LUI) ? 2'b11 : 2'b01;
                w_srcb = 2'b01;
                w_imm  = 3'b100;
                w_next = S_ALUWB;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    assign PCWrite    = w_pcwrite  & ~rst;
    assign IRWrite    = w_irwrite  & ~rst;
    assign MemWrite   = w_memwrite & ~rst;
    assign RegWrite   = w_regwrite & ~rst;
    assign AdrSrc     = w_adrsrc;
    assign ALUSrcA    = w_srca;
    assign ALUSrcB    = w_srcb;
    assign ResultSrc  = w_res;
    assign ImmSrc     = w_imm;
    assign ALUControl = w_alu;
    assign illegal    = r_illegal;
endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: per-instruction expected control sequences plus literal checks.
module tb_main_control_fsm;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instr;
    logic [3:0]  flags;
    logic        mem_ready;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        illegal;

    typedef struct packed {
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] srca, srcb, res;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ill;
    } ctl_t;

    ctl_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc_cnt, reg_cnt, pc_cnt;

    main_control_fsm dut (
        .clk(clk), .rst(rst), .Instr(Instr), .flags(flags), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic ctl_t mk(logic pcw, logic adr, logic memw, logic irw, logic regw,
                                logic [1:0] a, logic [1:0] b, logic [1:0] r,
                                logic [2:0] imm, logic [3:0] alu, logic ill);
        ctl_t c;
        c = '{pcw, adr, memw, irw, regw, a, b, r, imm, alu, ill};
        return c;
    endfunction

    // Expected per-cycle control words for one instruction, from the instruction-class rules
    function automatic void build(logic [31:0] ins, logic [3:0] alu, logic tk, int waits);
        logic [6:0] op;
        logic [2:0] f3;
        ctl_t wb, trap;
        op   = ins[6:0];
        f3   = ins[14:12];
        wb   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0);
        trap = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b1);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00,
                           (op == 7'h6F) ? 3'b011 : 3'b010, 4'b0000, 1'b0));
        if (op == 7'h03) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000, 1'b0));
            for (int i = 0; i <= waits; i++)
                exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0000, 1'b0));
        end else if (op == 7'h23) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b001, 4'b0000, 1'b0));
            exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0));
        end else if (op == 7'h33 || op == 7'h13) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, (op == 7'h13) ? 2'b01 : 2'b00,
                               2'b00, 3'b000, alu, 1'b0));
            exp_q.push_back(wb);
        end else if (op == 7'h63) begin
            exp_q.push_back(mk(tk, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0001, 1'b0));
            if (f3 == 3'b010 || f3 == 3'b011)
                for (int i = 0; i < 3; i++) exp_q.push_back(trap);
        end else if (op == 7'h6F || op == 7'h67) begin
            if (op == 7'h67)
                exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000, 1'b0));
            exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 3'b000, 4'b0000, 1'b0));
            exp_q.push_back(wb);
        end else if (op == 7'h37 || op == 7'h17) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (op == 7'h37) ? 2'b11 : 2'b01, 2'b01,
                               2'b00, 3'b100, 4'b0000, 1'b0));
            exp_q.push_back(wb);
        end else begin
            for (int i = 0; i < 3; i++) exp_q.push_back(trap);
        end
    endfunction

    // Single compare point: every queued cycle is checked on the falling edge
    always @(negedge clk) begin
        ctl_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB, ResultSrc,
                  ImmSrc, ALUControl, illegal};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cycle %08h @%0t: got %05h expected %05h", Instr, $time, a, e);
            end
            cyc_cnt++;
            reg_cnt += int'(RegWrite);
            pc_cnt  += int'(PCWrite);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input logic [31:0] ins, input logic [3:0] flg, input logic [3:0] alu,
                       input logic tk, input int lat, input int nreg, input int npc, input int lo_len);
        int  k, waits;
        logic is_trap;
`ifdef MEM_WAIT_EN
        waits = lo_len;
`else
        waits = 0;
`endif
        Instr = ins; flags = flg; mem_ready = 1'b1;
        cyc_cnt = 0; reg_cnt = 0; pc_cnt = 0;
        build(ins, alu, tk, waits);
        is_trap = !(ins[6:0] inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17})
                  || (ins[6:0] == 7'h63 && ins[14:13] == 2'b01);
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            mem_ready = !(k >= 3 && k < 3 + lo_len);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            check($sformatf("timeout %08h", ins), 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        check($sformatf("latency %08h", ins), cyc_cnt, lat);
        check($sformatf("regwrites %08h", ins), reg_cnt, nreg);
        check($sformatf("pcwrites %08h", ins), pc_cnt, npc);
        if (is_trap) begin
            check("illegal in trap", illegal, 1);
            check("enables in trap", {PCWrite, MemWrite, IRWrite, RegWrite}, 0);
            rst = 1'b1; #1;
            check("illegal async clear", illegal, 0);
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; Instr = 32'h0000007F; flags = 4'b0000; mem_ready = 1'b1;
        #12;
        check("reset outputs",
              {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal},
              32'b0000_0_00_10_10_000_0000_0);
        @(posedge clk); #1;
        rst = 1'b0;

        run(32'h002081B3, 4'b0000, 4'b0000, 1'b0, 4, 1, 1, 0);   // add
        run(32'h402081B3, 4'b0000, 4'b0001, 1'b0, 4, 1, 1, 0);   // sub
        run(32'h4020D1B3, 4'b0000, 4'b1001, 1'b0, 4, 1, 1, 0);   // sra
        run(32'h0020E1B3, 4'b0000, 4'b0011, 1'b0, 4, 1, 1, 0);   // or
        run(32'hC0000093, 4'b0000, 4'b0000, 1'b0, 4, 1, 1, 0);   // addi, bit30 set stays ADD
        run(32'h4030D093, 4'b0000, 4'b1001, 1'b0, 4, 1, 1, 0);   // srai
        run(32'h0010D093, 4'b0000, 4'b1000, 1'b0, 4, 1, 1, 0);   // srli
        run(32'h00101093, 4'b0000, 4'b0111, 1'b0, 4, 1, 1, 0);   // slli
        run(32'h00002093, 4'b0000, 4'b0101, 1'b0, 4, 1, 1, 0);   // slti
        run(32'h00003093, 4'b0000, 4'b0110, 1'b0, 4, 1, 1, 0);   // sltiu
        run(32'h0000C093, 4'b0000, 4'b0100, 1'b0, 4, 1, 1, 0);   // xori
        run(32'h0000F093, 4'b0000, 4'b0010, 1'b0, 4, 1, 1, 0);   // andi
`ifdef MEM_WAIT_EN
        run(32'h00012083, 4'b0000, 4'b0000, 1'b0, 8, 1, 1, 3);   // lw, 3 wait cycles
`else
        run(32'h00012083, 4'b0000, 4'b0000, 1'b0, 5, 1, 1, 3);   // lw, mem_ready ignored
`endif
        run(32'h00112023, 4'b0000, 4'b0000, 1'b0, 4, 0, 1, 0);   // sw
        run(32'h00000063, 4'b0001, 4'b0000, 1'b1, 3, 0, 2, 0);   // beq Z=1 taken
        run(32'h00001063, 4'b0001, 4'b0000, 1'b0, 3, 0, 1, 0);   // bne Z=1 not taken
        run(32'h00004063, 4'b0010, 4'b0000, 1'b1, 3, 0, 2, 0);   // blt N=1 V=0
        run(32'h00004063, 4'b1010, 4'b0000, 1'b0, 3, 0, 1, 0);   // blt N=1 V=1
        run(32'h00005063, 4'b0010, 4'b0000, 1'b0, 3, 0, 1, 0);   // bge N=1 V=0
        run(32'h00006063, 4'b0000, 4'b0000, 1'b1, 3, 0, 2, 0);   // bltu borrow
        run(32'h00007063, 4'b0100, 4'b0000, 1'b1, 3, 0, 2, 0);   // bgeu no borrow
        run(32'h000000EF, 4'b0000, 4'b0000, 1'b0, 4, 1, 2, 0);   // jal
        run(32'h000080E7, 4'b0000, 4'b0000, 1'b0, 5, 1, 2, 0);   // jalr x1,0(x1)
        run(32'h000010B7, 4'b0000, 4'b0000, 1'b0, 4, 1, 1, 0);   // lui
        run(32'h00001097, 4'b0000, 4'b0000, 1'b0, 4, 1, 1, 0);   // auipc
        run(32'h0000007F, 4'b0000, 4'b0000, 1'b0, 5, 0, 1, 0);   // illegal opcode
        run(32'h00002063, 4'b0001, 4'b0000, 1'b0, 6, 0, 1, 0);   // branch funct3 010

        // Reset while storing: MemWrite must drop without waiting for a clock
        Instr = 32'h00112023; flags = 4'b0000; mem_ready = 1'b1;
        cyc_cnt = 0; reg_cnt = 0; pc_cnt = 0;
        build(32'h00112023, 4'b0000, 1'b0, 0);
        repeat (3) begin @(posedge clk); #1; end
        exp_q.delete();
        check("memwrite before reset", MemWrite, 1);
        #2 rst = 1'b1;
        #1;
        check("memwrite async drop", MemWrite, 0);
        check("enables in reset", {PCWrite, IRWrite, RegWrite}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run(32'h002081B3, 4'b0000, 4'b0000, 1'b0, 4, 1, 1, 0);   // clean FETCH after abort

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
